// File: rtl/hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_fwd_ctrl
//   Hazard and forwarding controller for the 5-stage core. It drives the EX
//   operand mux selects, generates stall/flush controls for load-use,
//   taken-branch and multi-cycle mul/div cases, and owns the mul/div wait FSM
//   with its start/abort handshake, timeout, sticky error flag and a
//   saturating stall-cycle counter.
//
// Ports
//   clk, rstn                      clock (rising edge), async active-low reset
//   rs1_d, rs2_d, use_rs1_d/rs2_d  ID-stage sources and their read enables
//   rs1_e, rs2_e, rd_e             EX-stage sources / destination
//   regwrite_e, memread_e          EX writes rd / EX is a load
//   md_req_e, md_done              EX is an unfinished mul/div / result valid
//   branch_taken_e                 redirect resolved in EX
//   rd_m, regwrite_m               MEM-stage destination / write enable
//   rd_w, regwrite_w               WB-stage destination / write enable
//   fwd_a_e, fwd_b_e               00 regfile, 01 WB result, 10 MEM result
//   stall_f, stall_d, stall_e      hold PC / IF-ID / ID-EX
//   flush_d, flush_e, flush_m      bubble into IF-ID / ID-EX / EX-MEM
//   md_go, md_abort                one-cycle start / abort pulses
//   md_err                         sticky mul/div timeout flag
//   stall_cnt                      saturating count of cycles with stall_f=1
//
// State table
//   state   | meaning
//   ST_RUN  | normal flow: forwarding, load-use and branch handling
//   ST_WAIT | pipeline frozen waiting for md_done or timeout
// -----------------------------------------------------------------------------
module hazard_fwd_ctrl #(
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic             use_rs1_d,
    input  logic             use_rs2_d,
    input  logic [4:0]       rs1_e,
    input  logic [4:0]       rs2_e,
    input  logic [4:0]       rd_e,
    input  logic             regwrite_e,
    input  logic             memread_e,
    input  logic             md_req_e,
    input  logic             md_done,
    input  logic             branch_taken_e,
    input  logic [4:0]       rd_m,
    input  logic             regwrite_m,
    input  logic [4:0]       rd_w,
    input  logic             regwrite_w,
    output logic [1:0]       fwd_a_e,
    output logic [1:0]       fwd_b_e,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             flush_d,
    output logic             flush_e,
    output logic             flush_m,
    output logic             md_go,
    output logic             md_abort,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(MD_TIMEOUT - 1);

    state_t      state, state_nx;
    logic [15:0] wait_cnt, wait_nx;

    logic [1:0]  fwd_a_c, fwd_b_c;
    logic        lu;
    logic        stall_f_c, stall_d_c, stall_e_c;
    logic        flush_d_c, flush_e_c, flush_m_c;
    logic        md_go_c, md_abort_c;

    // A load always writes its destination, so regwrite_e adds nothing to
    // the load-use test.
    logic unused_regwrite_e;
    assign unused_regwrite_e = regwrite_e;

    // MEM result is younger than WB, so it wins; x0 is hardwired zero.
    always_comb begin
        fwd_a_c = 2'b00;
        if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs1_e))
            fwd_a_c = 2'b10;
        else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs1_e))
            fwd_a_c = 2'b01;

        fwd_b_c = 2'b00;
        if (regwrite_m && (rd_m != 5'd0) && (rd_m == rs2_e))
            fwd_b_c = 2'b10;
        else if (regwrite_w && (rd_w != 5'd0) && (rd_w == rs2_e))
            fwd_b_c = 2'b01;
    end

    assign lu = memread_e && (rd_e != 5'd0) &&
                ((use_rs1_d && (rd_e == rs1_d)) || (use_rs2_d && (rd_e == rs2_d)));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_RUN;
            wait_cnt <= 16'd0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        wait_nx    = wait_cnt;
        stall_f_c  = 1'b0;
        stall_d_c  = 1'b0;
        stall_e_c  = 1'b0;
        flush_d_c  = 1'b0;
        flush_e_c  = 1'b0;
        flush_m_c  = 1'b0;
        md_go_c    = 1'b0;
        md_abort_c = 1'b0;

        case (state)
            ST_RUN: begin
                if (md_req_e && !md_done) begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    stall_e_c = 1'b1;
                    flush_m_c = 1'b1;
                    md_go_c   = 1'b1;
                    state_nx  = ST_WAIT;
                    wait_nx   = 16'd0;
                end else if (branch_taken_e) begin
                    // The ID instruction is squashed, so a pending load-use
                    // hazard on it no longer matters.
                    flush_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end else if (lu) begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    flush_e_c = 1'b1;
                end
            end
            ST_WAIT: begin
                // Branch and load-use are ignored: the pipeline is frozen.
                wait_nx = wait_cnt + 16'd1;
                if (md_done) begin
                    // Release in the done cycle so the result lands in EX-MEM.
                    state_nx = ST_RUN;
                end else if (wait_cnt == TMO_LAST) begin
                    // No valid result exists, keep bubbling EX-MEM.
                    md_abort_c = 1'b1;
                    flush_m_c  = 1'b1;
                    state_nx   = ST_RUN;
                end else begin
                    stall_f_c = 1'b1;
                    stall_d_c = 1'b1;
                    stall_e_c = 1'b1;
                    flush_m_c = 1'b1;
                end
            end
            default: begin
                state_nx = ST_RUN;
                wait_nx  = 16'd0;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, even though the RUN
    // decode would otherwise react to live inputs.
    assign fwd_a_e  = rstn ? fwd_a_c : 2'b00;
    assign fwd_b_e  = rstn ? fwd_b_c : 2'b00;
    assign stall_f  = rstn & stall_f_c;
    assign stall_d  = rstn & stall_d_c;
    assign stall_e  = rstn & stall_e_c;
    assign flush_d  = rstn & flush_d_c;
    assign flush_e  = rstn & flush_e_c;
    assign flush_m  = rstn & flush_m_c;
    assign md_go    = rstn & md_go_c;
    assign md_abort = rstn & md_abort_c;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            md_err    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (md_abort_c)
                md_err <= 1'b1;
            if (stall_f_c && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_ctrl
//   Self-checking bench for hazard_fwd_ctrl (MD_TIMEOUT=8, CNT_W=4). Each
//   scenario task drives inputs after a rising edge and compares outputs on
//   the falling edge against expectations built from the hazard rules and
//   from per-operation cycle arithmetic (go cycle, done cycle, timeout cycle).
// -----------------------------------------------------------------------------
module tb_hazard_fwd_ctrl;

    localparam int T   = 8;
    localparam int CW  = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [4:0]    rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic          use_rs1_d, use_rs2_d, regwrite_e, memread_e;
    logic          md_req_e, md_done, branch_taken_e, regwrite_m, regwrite_w;
    logic [1:0]    fwd_a_e, fwd_b_e;
    logic          stall_f, stall_d, stall_e, flush_d, flush_e, flush_m;
    logic          md_go, md_abort, md_err;
    logic [CW-1:0] stall_cnt;

    // {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_go, md_abort}
    logic [7:0]    ctl;
    assign ctl = {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, md_go, md_abort};

    localparam logic [7:0] C_GO     = 8'hE6;
    localparam logic [7:0] C_WAIT   = 8'hE4;
    localparam logic [7:0] C_LU     = 8'hC8;
    localparam logic [7:0] C_BR     = 8'h18;
    localparam logic [7:0] C_ABORT  = 8'h01;
    localparam logic [7:0] M_ABORT  = 8'hFB;

    int   checks = 0;
    int   failures = 0;
    int   cnt_exp = 0;
    logic err_exp = 1'b0;

    always #5 clk = ~clk;

    hazard_fwd_ctrl #(.MD_TIMEOUT(T), .CNT_W(CW)) dut (
        .clk(clk), .rstn(rstn),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1_d(use_rs1_d), .use_rs2_d(use_rs2_d),
        .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
        .regwrite_e(regwrite_e), .memread_e(memread_e),
        .md_req_e(md_req_e), .md_done(md_done), .branch_taken_e(branch_taken_e),
        .rd_m(rd_m), .regwrite_m(regwrite_m), .rd_w(rd_w), .regwrite_w(regwrite_w),
        .fwd_a_e(fwd_a_e), .fwd_b_e(fwd_b_e),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_d(flush_d), .flush_e(flush_e), .flush_m(flush_m),
        .md_go(md_go), .md_abort(md_abort), .md_err(md_err), .stall_cnt(stall_cnt)
    );

    function automatic logic [1:0] fwd_ref(input logic [4:0] rs,
                                           input logic wm, input logic [4:0] dm,
                                           input logic ww, input logic [4:0] dw);
        if (wm && dm != 0 && dm == rs) return 2'd2;
        if (ww && dw != 0 && dw == rs) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic lu_ref(input logic mr, input logic [4:0] rde,
                                    input logic u1, input logic [4:0] r1,
                                    input logic u2, input logic [4:0] r2);
        return mr && rde != 0 && ((u1 && rde == r1) || (u2 && rde == r2));
    endfunction

    function automatic logic [7:0] run_ref(input logic req, input logic done,
                                           input logic br, input logic lu);
        if (req && !done) return C_GO;
        if (br)           return C_BR;
        if (lu)           return C_LU;
        return 8'h00;
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    task automatic clear_inputs;
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        use_rs1_d = 0; use_rs2_d = 0; regwrite_e = 0; memread_e = 0;
        md_req_e = 0; md_done = 0; branch_taken_e = 0; regwrite_m = 0; regwrite_w = 0;
    endtask

    task automatic cycle_end;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        clear_inputs();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        cnt_exp = 0;
        err_exp = 1'b0;
        cycle_end();
    endtask

    task automatic test_reset;
        clear_inputs();
        md_req_e = 1; memread_e = 1; rd_e = 4; use_rs1_d = 1; rs1_d = 4;
        regwrite_m = 1; rd_m = 6; rs1_e = 6;
        #2;
        checks++;
        if (ctl !== 8'h00) begin failures++; $display("FAIL reset_ctl: got %h expected 00", ctl); end
        checks++;
        if (fwd_a_e !== 2'b00) begin failures++; $display("FAIL reset_fwd_a: got %b expected 00", fwd_a_e); end
        checks++;
        if (md_err !== 1'b0 || stall_cnt !== '0) begin
            failures++; $display("FAIL reset_regs: got err=%b cnt=%0d expected 0/0", md_err, stall_cnt);
        end
        do_reset();
    endtask

    task automatic test_forward;
        logic [1:0] e;
        clear_inputs();
        regwrite_m = 1; rd_m = 5; regwrite_w = 1; rd_w = 5; rs1_e = 5; rs2_e = 5;
        @(negedge clk);
        checks++;
        if (fwd_a_e !== 2'b10 || fwd_b_e !== 2'b10) begin
            failures++; $display("FAIL fwd_mem_prio: got a=%b b=%b expected 10/10", fwd_a_e, fwd_b_e);
        end
        cycle_end();
        regwrite_m = 0;
        @(negedge clk);
        checks++;
        if (fwd_a_e !== 2'b01) begin failures++; $display("FAIL fwd_wb: got %b expected 01", fwd_a_e); end
        cycle_end();
        rd_w = 0; rs1_e = 0;
        @(negedge clk);
        checks++;
        if (fwd_a_e !== 2'b00) begin failures++; $display("FAIL fwd_x0: got %b expected 00", fwd_a_e); end
        cycle_end();
        for (int i = 0; i < 20; i++) begin
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_m = 5'($urandom_range(0, 3)); rd_w = 5'($urandom_range(0, 3));
            regwrite_m = 1'($urandom); regwrite_w = 1'($urandom);
            @(negedge clk);
            e = fwd_ref(rs2_e, regwrite_m, rd_m, regwrite_w, rd_w);
            checks++;
            if (fwd_b_e !== e) begin
                failures++; $display("FAIL fwd_b_rand: got %b expected %b", fwd_b_e, e);
            end
            cycle_end();
        end
        clear_inputs();
    endtask

    task automatic test_load_use;
        clear_inputs();
        memread_e = 1; rd_e = 7; use_rs2_d = 1; rs2_d = 7;
        @(negedge clk);
        checks++;
        if (ctl !== C_LU) begin failures++; $display("FAIL lu_ctl: got %h expected %h", ctl, C_LU); end
        cycle_end();
        cnt_exp = sat(cnt_exp + 1);
        memread_e = 0;
        @(negedge clk);
        checks++;
        if (ctl !== 8'h00 || stall_cnt !== CW'(cnt_exp)) begin
            failures++; $display("FAIL lu_clear: got ctl=%h cnt=%0d expected 00/%0d", ctl, stall_cnt, cnt_exp);
        end
        cycle_end();
        memread_e = 1; branch_taken_e = 1;
        @(negedge clk);
        checks++;
        if (ctl !== C_BR) begin failures++; $display("FAIL lu_branch: got %h expected %h", ctl, C_BR); end
        cycle_end();
        clear_inputs();
    endtask

    // One mul/div op starting in RUN. done_at: WAIT cycle index of md_done
    // (1 = first WAIT cycle), 0 = never. Branch/load-use noise is injected.
    task automatic test_md(input int done_at);
        logic [7:0] e, m;
        logic       fin;
        fin = 1'b0;
        for (int k = 0; k <= T && !fin; k++) begin
            md_req_e = 1;
            md_done = (k > 0 && k == done_at);
            branch_taken_e = 1'($urandom);
            memread_e = 1'($urandom); rd_e = 5'd9; use_rs1_d = 1; rs1_d = 5'd9;
            m = 8'hFF;
            if (k == 0)            e = C_GO;
            else if (md_done)      e = 8'h00;
            else if (k == T) begin e = C_ABORT; m = M_ABORT; end
            else                   e = C_WAIT;
            @(negedge clk);
            checks++;
            if ((ctl & m) !== e) begin
                failures++; $display("FAIL md_ctl k=%0d: got %h expected %h", k, ctl, e);
            end
            checks++;
            if (stall_cnt !== CW'(cnt_exp) || md_err !== err_exp) begin
                failures++;
                $display("FAIL md_regs k=%0d: got cnt=%0d err=%b expected %0d/%b", k, stall_cnt, md_err, cnt_exp, err_exp);
            end
            cycle_end();
            if (e[7]) cnt_exp = sat(cnt_exp + 1);
            if (e[0]) err_exp = 1'b1;
            if (k > 0 && (md_done || k == T)) fin = 1'b1;
        end
        clear_inputs();
    endtask

    task automatic test_muldiv;
        do_reset();
        test_md(5);
        @(negedge clk);
        checks++;
        if (ctl !== 8'h00 || stall_cnt !== CW'(5)) begin
            failures++; $display("FAIL md_after: got ctl=%h cnt=%0d expected 00/5", ctl, stall_cnt);
        end
        cycle_end();
    endtask

    task automatic test_timeout;
        do_reset();
        test_md(0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (md_err !== 1'b1 || ctl !== 8'h00) begin
                failures++; $display("FAIL tmo_sticky: got err=%b ctl=%h expected 1/00", md_err, ctl);
            end
            cycle_end();
        end
        test_md(3);
        @(negedge clk);
        checks++;
        if (md_err !== 1'b1) begin failures++; $display("FAIL tmo_after_ok: got err=%b expected 1", md_err); end
        cycle_end();
    endtask

    task automatic test_reset_mid_wait;
        clear_inputs();
        md_req_e = 1;
        for (int k = 0; k < 3; k++) begin
            cycle_end();
        end
        regwrite_m = 1; rd_m = 3; rs1_e = 3;
        #2;
        rstn = 1'b0;
        #1;
        checks++;
        if (ctl !== 8'h00 || fwd_a_e !== 2'b00) begin
            failures++; $display("FAIL rst_wait_out: got ctl=%h fwd=%b expected 00/00", ctl, fwd_a_e);
        end
        checks++;
        if (md_err !== 1'b0 || stall_cnt !== '0) begin
            failures++; $display("FAIL rst_wait_regs: got err=%b cnt=%0d expected 0/0", md_err, stall_cnt);
        end
        md_req_e = 0;
        cycle_end();
        checks++;
        if (md_abort !== 1'b0) begin failures++; $display("FAIL rst_wait_abort: got %b expected 0", md_abort); end
        @(negedge clk);
        rstn = 1'b1;
        cnt_exp = 0; err_exp = 1'b0;
        cycle_end();
        @(negedge clk);
        checks++;
        if (ctl !== 8'h00 || fwd_a_e !== 2'b10) begin
            failures++; $display("FAIL rst_wait_run: got ctl=%h fwd=%b expected 00/10", ctl, fwd_a_e);
        end
        cycle_end();
        md_req_e = 1;
        @(negedge clk);
        checks++;
        if (ctl !== C_GO) begin failures++; $display("FAIL rst_wait_go: got %h expected %h", ctl, C_GO); end
        cycle_end();
        cnt_exp = sat(cnt_exp + 1);
        md_done = 1;
        @(negedge clk);
        checks++;
        if (ctl !== 8'h00 || stall_cnt !== CW'(cnt_exp)) begin
            failures++; $display("FAIL rst_wait_done: got ctl=%h cnt=%0d expected 00/%0d", ctl, stall_cnt, cnt_exp);
        end
        cycle_end();
        clear_inputs();
    endtask

    task automatic test_done_at_timeout;
        do_reset();
        test_md(T);
        @(negedge clk);
        checks++;
        if (md_err !== 1'b0) begin failures++; $display("FAIL done_tmo_err: got %b expected 0", md_err); end
        cycle_end();
    endtask

    task automatic test_back_to_back;
        test_md(2);
        test_md(3);
        @(negedge clk);
        checks++;
        if (ctl !== 8'h00 || stall_cnt !== CW'(cnt_exp)) begin
            failures++; $display("FAIL b2b_after: got ctl=%h cnt=%0d expected 00/%0d", ctl, stall_cnt, cnt_exp);
        end
        cycle_end();
    endtask

    task automatic test_random_run;
        logic [7:0] e;
        logic [1:0] ea, eb;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            rs1_d = 5'($urandom_range(0, 3)); rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3)); rs2_e = 5'($urandom_range(0, 3));
            rd_e = 5'($urandom_range(0, 3)); rd_m = 5'($urandom_range(0, 3));
            rd_w = 5'($urandom_range(0, 3));
            use_rs1_d = 1'($urandom); use_rs2_d = 1'($urandom);
            regwrite_e = 1'($urandom); memread_e = 1'($urandom);
            regwrite_m = 1'($urandom); regwrite_w = 1'($urandom);
            branch_taken_e = 1'($urandom);
            md_done = 1'($urandom);
            md_req_e = md_done ? 1'($urandom) : 1'b0;
            e  = run_ref(md_req_e, md_done, branch_taken_e,
                         lu_ref(memread_e, rd_e, use_rs1_d, rs1_d, use_rs2_d, rs2_d));
            ea = fwd_ref(rs1_e, regwrite_m, rd_m, regwrite_w, rd_w);
            eb = fwd_ref(rs2_e, regwrite_m, rd_m, regwrite_w, rd_w);
            @(negedge clk);
            checks++;
            if (ctl !== e || fwd_a_e !== ea || fwd_b_e !== eb) begin
                failures++;
                $display("FAIL rand_run i=%0d: got ctl=%h a=%b b=%b expected %h/%b/%b", i, ctl, fwd_a_e, fwd_b_e, e, ea, eb);
            end
            checks++;
            if (stall_cnt !== CW'(cnt_exp)) begin
                failures++; $display("FAIL rand_cnt i=%0d: got %0d expected %0d", i, stall_cnt, cnt_exp);
            end
            cycle_end();
            if (e[7]) cnt_exp = sat(cnt_exp + 1);
        end
        clear_inputs();
    endtask

    task automatic test_saturation;
        do_reset();
        memread_e = 1; rd_e = 5; use_rs1_d = 1; rs1_d = 5;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (ctl !== C_LU || stall_cnt !== CW'(sat(k))) begin
                failures++; $display("FAIL sat_run k=%0d: got ctl=%h cnt=%0d expected %h/%0d", k, ctl, stall_cnt, C_LU, sat(k));
            end
            cycle_end();
        end
        clear_inputs();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (stall_cnt !== CW'(MAXC)) begin
                failures++; $display("FAIL sat_hold: got %0d expected %0d", stall_cnt, MAXC);
            end
            cycle_end();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_inputs();
        test_reset();
        test_forward();
        test_load_use();
        test_muldiv();
        test_timeout();
        test_reset_mid_wait();
        test_done_at_timeout();
        test_back_to_back();
        test_random_run();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
